// File: rtl/delay_buffer_ctrl.sv
// Per-sample delay/echo/looper engine over a word-addressed circular buffer.
// One sample in flight: read delayed tap, mix with dry, optionally write back, present result.
module delay_buffer_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [7:0]        gain,
  input  logic              record,
  input  logic              loop,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  input  logic              out_ready
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MIX  = 3'd2,
    ST_WR   = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);

  state_t                   state_r;
  state_t                   state_nx_s;
  logic [ADDR_W-1:0]        wr_ptr_r;
  logic signed [DATA_W-1:0] x_r;
  logic signed [DATA_W-1:0] d_r;
  logic signed [DATA_W-1:0] y_r;
  logic signed [DATA_W-1:0] mix_s;
  logic [7:0]               gain_r;
  logic                     record_r;
  logic                     loop_r;
  logic                     mem_req_r;
  logic                     mem_we_r;
  logic [ADDR_W-1:0]        mem_addr_r;
  logic [DATA_W-1:0]        mem_wdata_r;
  logic                     out_valid_r;
  logic                     in_ready_r;
  logic                     accept_s;

  // y = sat(x + ((d * {0,gain}) >>> 8)); the slice of the wide product is the arithmetic shift
  function automatic logic signed [DATA_W-1:0] mix_sat(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] d,
    input logic [7:0]               g
  );
    logic signed [DATA_W+8:0] prod;
    logic signed [DATA_W:0]   wet;
    logic signed [DATA_W+1:0] sum;
    prod = $signed({{9{d[DATA_W-1]}}, d}) * $signed({{(DATA_W+1){1'b0}}, g});
    wet  = prod[DATA_W+8:8];
    sum  = {x[DATA_W-1], x[DATA_W-1], x} + {wet[DATA_W], wet};
    if (sum[DATA_W+1:DATA_W-1] == {3{sum[DATA_W+1]}}) begin
      return sum[DATA_W-1:0];
    end else if (sum[DATA_W+1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  assign accept_s   = in_valid & in_ready_r;
  assign mix_s      = mix_sat(x_r, d_r, gain_r);

  assign in_ready   = in_ready_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign out_valid  = out_valid_r;
  assign out_sample = y_r;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; acks only matter while a request is outstanding
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_RD;
        else          state_nx_s = ST_IDLE;
      end
      ST_RD: begin
        if (mem_ack) state_nx_s = ST_MIX;
        else         state_nx_s = ST_RD;
      end
      ST_MIX: begin
        if (loop_r) state_nx_s = ST_OUT;
        else        state_nx_s = ST_WR;
      end
      ST_WR: begin
        if (mem_ack) state_nx_s = ST_OUT;
        else         state_nx_s = ST_WR;
      end
      ST_OUT: begin
        if (out_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_OUT;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they line up with it
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      mem_req_r   <= (state_nx_s == ST_RD) || (state_nx_s == ST_WR);
      mem_we_r    <= (state_nx_s == ST_WR);
      out_valid_r <= (state_nx_s == ST_OUT);
      in_ready_r  <= (state_nx_s == ST_IDLE);
    end
  end

  // Per-sample latches, memory address/data and the circular write pointer
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      x_r         <= {DATA_W{1'b0}};
      d_r         <= {DATA_W{1'b0}};
      y_r         <= {DATA_W{1'b0}};
      gain_r      <= 8'd0;
      record_r    <= 1'b0;
      loop_r      <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            x_r        <= in_sample;
            gain_r     <= gain;
            record_r   <= record;
            loop_r     <= loop;
            // delay_len of 0 wraps onto wr_ptr itself: a full-depth tap
            mem_addr_r <= wr_ptr_r - delay_len;
          end
        end
        ST_RD: begin
          if (mem_ack) d_r <= mem_rdata;
        end
        ST_MIX: begin
          y_r <= mix_s;
          if (!loop_r) begin
            mem_addr_r  <= wr_ptr_r;
            mem_wdata_r <= record_r ? mix_s : x_r;
          end
        end
        ST_WR: begin
          mem_addr_r <= mem_addr_r;
        end
        ST_OUT: begin
          if (out_ready) wr_ptr_r <= wr_ptr_r + PTR_STEP;
        end
        default: begin
          mem_addr_r <= mem_addr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_buffer_ctrl.sv
// Self-checking bench for delay_buffer_ctrl with a 16-word buffer and a negedge memory model.
module tb_delay_buffer_ctrl;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_sample = '0;
  logic          in_ready;
  logic [AW-1:0] delay_len = '0;
  logic [7:0]    gain = '0;
  logic          record = 1'b0;
  logic          loop = 1'b0;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          out_valid;
  logic [DW-1:0] out_sample;
  logic          out_ready = 1'b0;

  always #5 clk = ~clk;

  delay_buffer_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .delay_len(delay_len), .gain(gain), .record(record), .loop(loop),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .out_sample(out_sample), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic signed [DW-1:0] mem [16];
  logic signed [DW-1:0] pre_val [16];
  int      pre_req = 0, pre_seen = 0;
  logic    mem_auto = 1'b1, rand_wait = 1'b0;
  logic    auto_ack = 1'b0, man_ack = 1'b0;
  logic [DW-1:0] auto_rdata = '0, man_rdata = '0;
  int      cur_wait = 0, wcnt = 0, last_rd = -1, we_cyc = 0;

  assign mem_ack   = mem_auto ? auto_ack : man_ack;
  assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

  always @(negedge clk) begin
    if (pre_req != pre_seen) begin
      for (int i = 0; i < 16; i++) mem[i] = pre_val[i];
      pre_seen = pre_req;
    end
    if (mem_req && mem_we) we_cyc++;
    if (!mem_auto) begin
      auto_ack = 1'b0;
      wcnt = 0;
    end else if (auto_ack) begin
      auto_ack = 1'b0;
    end else if (mem_req) begin
      if (wcnt > cur_wait) begin
        auto_ack = 1'b1;
        wcnt = 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else begin
          auto_rdata = mem[mem_addr];
          last_rd = int'(mem_addr);
        end
        cur_wait = rand_wait ? int'($urandom_range(3, 0)) : 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic load_mem();
    int tmo;
    pre_req++;
    tmo = 0;
    while (pre_seen != pre_req && tmo < 10) begin @(negedge clk); tmo++; end
    check("mem_preload", pre_seen, pre_req);
  endtask

  // ---------------- protocol monitor ----------------
  logic mon_en = 1'b0;
  initial begin
    logic          p_req, p_we, p_ov;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd, p_os;
    p_req = 1'b0; p_we = 1'b0; p_ov = 1'b0; p_addr = '0; p_wd = '0; p_os = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (p_req && mem_req) begin
          check("mem_addr_stable", int'(mem_addr), int'(p_addr));
          check("mem_we_stable", int'(mem_we), int'(p_we));
          check("mem_wdata_stable", int'(mem_wdata), int'(p_wd));
        end
        if (p_ov && !out_ready) begin
          check("out_valid_held", int'(out_valid), 1);
          check("out_sample_held", int'(out_sample), int'(p_os));
        end
        if (mem_req || out_valid) check("in_ready_busy", int'(in_ready), 0);
        if (out_valid && out_ready == 1'b0) check("no_mem_in_out", int'(mem_req), 0);
      end
      p_req = mem_req; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
      p_ov = out_valid; p_os = out_sample;
    end
  end

  // ---------------- sample driver ----------------
  task automatic run_sample(input int x, input int dl, input int g, input int rec, input int lp,
                            input int hold, output int y, output int lat);
    int tmo;
    y = 0; lat = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sample = DW'(x); delay_len = AW'(dl); gain = 8'(g);
    record = rec[0]; loop = lp[0];
    tmo = 0;
    while (!in_ready && tmo < 100) begin @(negedge clk); tmo++; end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // scramble controls after accept; they must not affect this sample
    in_valid = 1'b0; in_sample = ~in_sample; delay_len = ~delay_len; gain = ~gain;
    record = ~record; loop = ~loop;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    repeat (hold) @(negedge clk);
    y = int'($signed(out_sample));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_out", int'(in_ready), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    wb_rst_i = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    wb_rst_i = 1'b0;
  endtask

  function automatic int model_mix(input int x, input int d, input int g);
    int s;
    s = x + ((d * g) >>> 8);
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s;
  endfunction

  typedef struct {
    int x; int dl; int g; int rec; int lp; int y;
  } vec_t;

  vec_t tbl [14];
  int   ref_mem [16];

  initial begin
    int y, lat, ref_ptr, we_snap, exp_y, d, tmo;

    tbl[0]  = '{100,    3, 255, 0, 0, 100};
    tbl[1]  = '{200,    3, 255, 0, 0, 200};
    tbl[2]  = '{300,    3, 255, 0, 0, 300};
    tbl[3]  = '{400,    3, 255, 0, 0, 499};
    tbl[4]  = '{500,    3, 255, 0, 0, 699};
    tbl[5]  = '{32000, 11, 128, 0, 0, 32767};
    tbl[6]  = '{-32768,11, 128, 0, 0, -32768};
    tbl[7]  = '{5,     11,   1, 0, 0, 4};
    tbl[8]  = '{7,      1,   0, 0, 0, 7};
    tbl[9]  = '{-100,   1, 255, 1, 0, -94};
    tbl[10] = '{0,      1, 255, 1, 0, -94};
    tbl[11] = '{1000,   0,  64, 0, 0, -7192};
    tbl[12] = '{-32768, 7, 255, 0, 1, -893};
    tbl[13] = '{0,      1, 255, 0, 0, -1};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_out_sample", int'(out_sample), 0);
    check("rst_in_ready", int'(in_ready), 0);
    wb_rst_i = 1'b0;

    // table: plain delay, saturation, rounding, feedback write, loop no-write
    for (int i = 0; i < 16; i++) pre_val[i] = '0;
    pre_val[10] = 16'sd32767;
    pre_val[11] = -16'sd32768;
    pre_val[12] = -16'sd1;
    load_mem();
    for (int i = 0; i < 14; i++) begin
      run_sample(tbl[i].x, tbl[i].dl, tbl[i].g, tbl[i].rec, tbl[i].lp, 0, y, lat);
      check($sformatf("tbl_y[%0d]", i), y, tbl[i].y);
      check($sformatf("tbl_latency[%0d]", i), lat, (tbl[i].lp != 0) ? 4 : 6);
    end
    for (int i = 0; i < 5; i++) check($sformatf("tbl_mem[%0d]", i), int'(mem[i]), 100 * (i + 1));
    check("tbl_mem[9]", int'(mem[9]), -94);
    check("tbl_mem[10]", int'(mem[10]), -94);
    check("tbl_mem[11]", int'(mem[11]), 1000);
    check("tbl_mem[12]_frozen", int'(mem[12]), -1);

    // loop freeze: record 16, replay 20 with no writes
    do_reset();
    for (int i = 0; i < 16; i++) pre_val[i] = '0;
    load_mem();
    for (int k = 0; k < 16; k++) run_sample(256 * (k + 1), 1, 0, 0, 0, 0, y, lat);
    we_snap = we_cyc;
    for (int k = 0; k < 20; k++) begin
      run_sample(0, 0, 255, 1, 1, 0, y, lat);
      check($sformatf("loop_rd_addr[%0d]", k), last_rd, k % 16);
      check($sformatf("loop_y[%0d]", k), y, 255 * ((k % 16) + 1));
    end
    check("loop_no_writes", we_cyc, we_snap);

    // feedback echo with full-depth delay
    do_reset();
    load_mem();
    for (int k = 0; k < 49; k++) begin
      run_sample((k == 0) ? 1000 : 0, 0, 128, 1, 0, 0, y, lat);
      case (k)
        0:       exp_y = 1000;
        16:      exp_y = 500;
        32:      exp_y = 250;
        48:      exp_y = 125;
        default: exp_y = 0;
      endcase
      check($sformatf("fb_y[%0d]", k), y, exp_y);
    end

    // handshake stress: random waits, out_ready held low 5 cycles
    do_reset();
    load_mem();
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    ref_ptr = 0;
    rand_wait = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int x, dl, g, rec, lp;
      x = int'($urandom_range(65535, 0)) - 32768;
      dl = int'($urandom_range(15, 0));
      g = int'($urandom_range(255, 0));
      rec = int'($urandom_range(1, 0));
      lp = int'($urandom_range(1, 0));
      d = ref_mem[(ref_ptr - dl) & 15];
      exp_y = model_mix(x, d, g);
      if (lp == 0) ref_mem[ref_ptr] = (rec != 0) ? exp_y : x;
      ref_ptr = (ref_ptr + 1) & 15;
      run_sample(x, dl, g, rec, lp, 5, y, lat);
      check($sformatf("stress_y[%0d]", k), y, exp_y);
    end
    mon_en = 1'b0;
    rand_wait = 1'b0;
    for (int i = 0; i < 16; i++) check($sformatf("stress_mem[%0d]", i), int'(mem[i]), ref_mem[i]);

    // reset during WR before ack; late ack must be ignored
    do_reset();
    load_mem();
    mem_auto = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_sample = 16'd123; delay_len = 4'd3; gain = 8'd0; record = 1'b0; loop = 1'b0;
    tmo = 0;
    while (!in_ready && tmo < 20) begin @(negedge clk); tmo++; end
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_test_rd_req", int'(mem_req && !mem_we), 1);
    check("rst_test_rd_addr", int'(mem_addr), 13);
    man_rdata = '0; man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    tmo = 0;
    while (!(mem_req && mem_we) && tmo < 20) begin @(negedge clk); tmo++; end
    check("rst_test_wr_req", int'(mem_req && mem_we), 1);
    @(negedge clk);
    wb_rst_i = 1'b1;
    @(negedge clk);
    check("rst_abort_mem_req", int'(mem_req), 0);
    check("rst_abort_out_valid", int'(out_valid), 0);
    check("rst_abort_in_ready", int'(in_ready), 0);
    wb_rst_i = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    check("late_ack_mem_req", int'(mem_req), 0);
    check("late_ack_out_valid", int'(out_valid), 0);
    check("late_ack_in_ready", int'(in_ready), 1);
    mem_auto = 1'b1;
    run_sample(50, 3, 255, 0, 0, 0, y, lat);
    check("post_rst_rd_addr", last_rd, 13);
    check("post_rst_y", y, 50);
    check("post_rst_wr_mem0", int'(mem[0]), 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
